// File: rtl/dmg_dma_pkg.sv
// Shared types and constants for the DMG OAM DMA sequencer.
// State encoding, OAM size and the echo-RAM page fold.
package dmg_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    FLUSH = 2'd3
  } dma_state_t;

  localparam int         OAM_LEN   = 160;
  localparam logic [7:0] ECHO_BASE = 8'hE0;

  // Pages E0..FF alias the work RAM at C0..DF
  function automatic logic [7:0] echo_fold(
    input logic [7:0] page
  );
    return (page >= ECHO_BASE) ?
      (page & 8'hDF) : page;
  endfunction

endpackage

// File: rtl/dmg_dma_wrpipe.sv
// Write-stage register: holds one fetched byte and its
// destination index for one cycle, with a pending flag.
module dmg_dma_wrpipe (
  input  logic       clk,
  input  logic       nres,
  input  logic       ld,
  input  logic       clr,
  input  logic [7:0] d,
  input  logic [7:0] idx,
  output logic       pend,
  output logic [7:0] wr_idx,
  output logic [7:0] data_q
);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      pend   <= 1'b0;
      wr_idx <= 8'h00;
      data_q <= 8'h00;
    end else if (ld) begin
      pend   <= 1'b1;
      wr_idx <= idx;
      data_q <= d;
    end else if (clr) begin
      pend   <= 1'b0;
    end
  end

endmodule

// File: rtl/dmg_oam_dma.sv
// FF46 OAM DMA sequencer: copies one source page into OAM,
// one byte per M-cycle, and owns the bus while doing so.
module dmg_oam_dma
  import dmg_dma_pkg::*;
#(
  parameter int LEN         = OAM_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        nres,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  ext_d,
  output logic        dma_rd,
  output logic [15:0] dma_a,
  output logic        oam_wr,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_d,
  output logic        cpu_block,
  output logic        dma_active
);

  localparam logic [7:0] IDX_LAST = 8'(LEN - 1);
  localparam logic [7:0] DLY_LAST = 8'(START_DELAY - 1);

  dma_state_t state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       restart_q, restart_d;
  logic       ld;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q   <= IDLE;
      src_q     <= 8'h00;
      idx_q     <= 8'h00;
      dcnt_q    <= 8'h00;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
      dcnt_q    <= dcnt_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    idx_d     = idx_q;
    dcnt_d    = dcnt_q;
    restart_d = restart_q;
    unique case (state_q)
      IDLE:  state_d = IDLE;
      START: begin
        if (dcnt_q == DLY_LAST) begin
          state_d = XFER;
          idx_d   = 8'h00;
        end else begin
          dcnt_d  = dcnt_q + 8'd1;
        end
      end
      XFER: begin
        if (idx_q == IDX_LAST) begin
          state_d = FLUSH;
          idx_d   = 8'h00;
        end else begin
          idx_d   = idx_q + 8'd1;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new FF46 write overrides whatever is in flight
    if (reg_wr) begin
      state_d   = START;
      src_d     = din;
      idx_d     = 8'h00;
      dcnt_d    = 8'h00;
      restart_d = (state_q == XFER)
               || (state_q == FLUSH)
               || (state_q == START && restart_q);
    end
  end

  // The byte fetched on a restart edge is dropped
  assign ld = (state_q == XFER) && !reg_wr;

  dmg_dma_wrpipe u_wrpipe (
    .clk    (clk),
    .nres   (nres),
    .ld     (ld),
    .clr    (!ld),
    .d      (ext_d),
    .idx    (idx_q),
    .pend   (oam_wr),
    .wr_idx (oam_a),
    .data_q (oam_d)
  );

  assign dma_rd     = (state_q == XFER);
  assign dma_a      = {echo_fold(src_q), idx_q};
  assign dma_active = (state_q != IDLE);
  assign cpu_block  = (state_q == XFER)
                   || (state_q == FLUSH)
                   || (state_q == START && restart_q);
  assign dout       = reg_rd ? src_q : 8'h00;

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Randomised bench for dmg_oam_dma against a timeline model
// keyed on the cycle of the latest FF46 write.
module tb_dmg_oam_dma;

  localparam int LEN = 160;
  localparam int SD  = 1;

  logic        clk = 1'b0;
  logic        nres = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  ext_d = 8'h00;
  logic [7:0]  dout;
  logic        dma_rd;
  logic [15:0] dma_a;
  logic        oam_wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_d;
  logic        cpu_block;
  logic        dma_active;

  always #5 clk = ~clk;

  dmg_oam_dma #(.LEN(LEN), .START_DELAY(SD)) dut (
    .clk        (clk),
    .nres       (nres),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .din        (din),
    .dout       (dout),
    .ext_d      (ext_d),
    .dma_rd     (dma_rd),
    .dma_a      (dma_a),
    .oam_wr     (oam_wr),
    .oam_a      (oam_a),
    .oam_d      (oam_d),
    .cpu_block  (cpu_block),
    .dma_active (dma_active)
  );

  int total = 0;
  int bad   = 0;

  // Model: a transfer is a timeline starting at the edge
  // of its FF46 write; everything derives from the offset.
  int         cyc = 0;
  int         base = 0;
  bit         have = 0;
  bit         rs = 0;
  logic [7:0] page = 8'h00;
  logic [7:0] cur_ext = 8'h00;
  logic [7:0] prev_ext = 8'h00;

  function automatic logic [43:0] expect_vec(
    output bit er, output bit ew
  );
    logic        blk, act;
    logic [15:0] a;
    logic [7:0]  oa, od, fp;
    int          d;
    er = 0; ew = 0; blk = 0; act = 0;
    a = 16'h0; oa = 8'h0; od = 8'h0;
    fp = (page >= 8'hE0) ? page - 8'h20 : page;
    if (have) begin
      d = cyc - base;
      if (d < SD) begin
        act = 1; blk = rs;
      end else if (d < SD + LEN) begin
        act = 1; blk = 1; er = 1;
        a = {fp, 8'(d - SD)};
        if (d > SD) begin
          ew = 1; oa = 8'(d - SD - 1); od = prev_ext;
        end
      end else if (d == SD + LEN) begin
        act = 1; blk = 1; ew = 1;
        oa = 8'(LEN - 1); od = prev_ext;
      end
    end
    return {er, a, ew, oa, od, blk, act,
            reg_rd ? page : 8'h00};
  endfunction

  function automatic logic [43:0] dut_vec(
    input bit sr, input bit sw
  );
    return {dma_rd, sr ? dma_a : 16'h0,
            oam_wr, sw ? oam_a : 8'h0,
            sw ? oam_d : 8'h0,
            cpu_block, dma_active, dout};
  endfunction

  task automatic tick();
    logic [43:0] ev;
    bit er, ew, blk;
    ev  = expect_vec(er, ew);
    blk = ev[9];
    @(posedge clk);
    cyc++;
    if (nres && reg_wr) begin
      rs = blk; page = din; have = 1; base = cyc;
    end
    prev_ext = cur_ext;
    #1;
    ext_d   = 8'($urandom);
    cur_ext = ext_d;
  endtask

  task automatic test_reset();
    logic [43:0] ev;
    bit er, ew;
    reg_rd = 1;
    #2;
    total++;
    if (dut_vec(1, 1) !== 44'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0",
               dut_vec(1, 1));
    end
    tick(); tick();
    @(negedge clk) nres = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL reset_idle got=%h exp=%h",
                 dut_vec(er, ew), ev);
      end
    end
    reg_rd = 0;
  endtask

  task automatic test_basic();
    logic [43:0] ev;
    bit er, ew;
    int nw, t0;
    logic [15:0] fa, la;
    nw = 0; fa = 16'h0; la = 16'h0;
    reg_wr = 1; din = 8'hC1;
    tick();
    reg_wr = 0; t0 = cyc;
    for (int i = 0; i <= SD + LEN + 2; i++) begin
      if (i > 0) tick();
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL basic c=%0d got=%h exp=%h",
                 i, dut_vec(er, ew), ev);
      end
      if (oam_wr) nw++;
      if (i == SD) fa = dma_a;
      if (i == SD + LEN - 1) la = dma_a;
    end
    total += 3;
    if (fa !== 16'hC100) begin
      bad++;
      $display("FAIL basic_first got=%h exp=c100", fa);
    end
    if (la !== 16'hC19F) begin
      bad++;
      $display("FAIL basic_last got=%h exp=c19f", la);
    end
    if (nw != LEN) begin
      bad++;
      $display("FAIL basic_count got=%0d exp=%0d",
               nw, LEN);
    end
  endtask

  task automatic test_echo();
    logic [43:0] ev;
    bit er, ew;
    logic [15:0] fa;
    logic [7:0]  rb;
    fa = 16'h0; rb = 8'h0;
    reg_rd = 1; reg_wr = 1; din = 8'hFE;
    tick();
    reg_wr = 0;
    for (int i = 0; i <= SD + LEN + 1; i++) begin
      if (i > 0) tick();
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL echo c=%0d got=%h exp=%h",
                 i, dut_vec(er, ew), ev);
      end
      if (i == SD) begin
        fa = dma_a; rb = dout;
      end
    end
    total += 2;
    if (fa !== 16'hDE00) begin
      bad++;
      $display("FAIL echo_first got=%h exp=de00", fa);
    end
    if (rb !== 8'hFE) begin
      bad++;
      $display("FAIL echo_dout got=%h exp=fe", rb);
    end
    reg_rd = 0;
  endtask

  task automatic test_restart();
    logic [43:0] ev;
    bit er, ew, gap;
    gap = 0;
    reg_wr = 1; din = 8'h80;
    tick();
    reg_wr = 0;
    for (int i = 0; i <= 50 + SD + LEN + 1; i++) begin
      if (i > 0) tick();
      reg_wr = 0;
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL restart c=%0d got=%h exp=%h",
                 i, dut_vec(er, ew), ev);
      end
      if (i >= 1 && i <= 50 + SD + LEN && !cpu_block)
        gap = 1;
      if (i == 49) begin
        reg_wr = 1; din = 8'h90;
      end
    end
    total++;
    if (gap !== 1'b0) begin
      bad++;
      $display("FAIL restart_block got=%0b exp=0", gap);
    end
  endtask

  task automatic test_collision();
    logic [43:0] ev;
    bit er, ew;
    int hit;
    hit = -1;
    reg_wr = 1; din = 8'hA0;
    tick();
    reg_wr = 0;
    for (int i = 0; i <= 2 * (SD + LEN) + 1; i++) begin
      if (i > 0) tick();
      reg_wr = 0;
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL collide c=%0d got=%h exp=%h",
                 i, dut_vec(er, ew), ev);
      end
      if (i == SD + LEN) begin
        total++;
        if ({oam_wr, cpu_block, dma_active} !== 3'b011)
        begin
          bad++;
          $display("FAIL collide_noflush got=%b exp=011",
                   {oam_wr, cpu_block, dma_active});
        end
      end
      if (i == SD + LEN - 1) begin
        reg_wr = 1; din = 8'hA0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [43:0] ev;
    bit er, ew;
    int ns;
    ns = 0;
    reg_wr = 1; din = 8'h55;
    tick();
    reg_wr = 0;
    for (int i = 1; i <= 80; i++) tick();
    #3 nres = 0;
    #1;
    have = 0; page = 8'h00; rs = 0;
    total++;
    if (dut_vec(1, 1) !== 44'h0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0",
               dut_vec(1, 1));
    end
    tick(); tick();
    @(negedge clk) nres = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL reset_after got=%h exp=%h",
                 dut_vec(er, ew), ev);
      end
      if (oam_wr || dma_rd) ns++;
    end
    total++;
    if (ns != 0) begin
      bad++;
      $display("FAIL reset_strobes got=%0d exp=0", ns);
    end
  endtask

  task automatic test_random();
    logic [43:0] ev;
    bit er, ew;
    for (int i = 0; i < 700; i++) begin
      reg_wr = ($urandom_range(0, 119) == 0);
      din    = 8'($urandom);
      reg_rd = 1'($urandom);
      tick();
      ev = expect_vec(er, ew);
      total++;
      if (dut_vec(er, ew) !== ev) begin
        bad++;
        $display("FAIL random c=%0d got=%h exp=%h",
                 i, dut_vec(er, ew), ev);
      end
    end
    reg_wr = 0;
    reg_rd = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_echo();
    test_restart();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
